// File: rtl/tx_port_channel_gate_sync.sv
// Same-clock TX channel gate: latches the channel request into a TXN handshake for the engine,
// and streams channel beats into the TX FIFO followed by a terminator entry.
module tx_port_channel_gate_sync #(
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CHNL_TX,
    output logic                    CHNL_TX_ACK,
    input  logic                    CHNL_TX_LAST,
    input  logic [31:0]             CHNL_TX_LEN,
    input  logic [30:0]             CHNL_TX_OFF,
    input  logic [C_DATA_WIDTH-1:0] CHNL_TX_DATA,
    input  logic                    CHNL_TX_DATA_VALID,
    output logic                    CHNL_TX_DATA_REN,
    output logic [C_DATA_WIDTH:0]   WR_DATA,
    output logic                    WR_EN,
    input  logic                    WR_FULL,
    output logic                    TXN,
    input  logic                    TXN_ACK,
    output logic                    TXN_LAST,
    output logic [31:0]             TXN_LEN,
    output logic [30:0]             TXN_OFF,
    output logic [31:0]             TX_SENT,
    output logic                    TX_DONE
);

    localparam int unsigned Words = C_DATA_WIDTH / 32;

    typedef enum logic [1:0] {StIdle, StAck, StData, StEop} state_e;

    state_e      state_q, state_d;
    logic        txn_q;
    logic        txn_last_q;
    logic [31:0] txn_len_q;
    logic [30:0] txn_off_q;
    logic [31:0] tx_sent_q;
    logic        tx_done_q;
    logic        start;
    logic        beat;
    logic        term;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (CHNL_TX && !txn_q) state_d = StAck;
            StAck:   state_d = StData;
            StData:  if (!CHNL_TX) state_d = StEop;
            StEop:   if (!WR_FULL) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        CHNL_TX_DATA_REN = 1'b0;
        WR_EN            = 1'b0;
        WR_DATA          = '0;
        start            = 1'b0;
        beat             = 1'b0;
        term             = 1'b0;
        unique case (state_q)
            // A still-pending TXN blocks the next request until the engine takes it.
            StIdle: start = CHNL_TX && !txn_q;
            StData: begin
                CHNL_TX_DATA_REN = !WR_FULL;
                beat             = CHNL_TX_DATA_VALID && !WR_FULL;
                if (beat) begin
                    WR_EN   = 1'b1;
                    WR_DATA = {1'b0, CHNL_TX_DATA};
                end
            end
            StEop: begin
                if (!WR_FULL) begin
                    term    = 1'b1;
                    WR_EN   = 1'b1;
                    WR_DATA = {1'b1, {C_DATA_WIDTH{1'b0}}};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            txn_q      <= 1'b0;
            txn_last_q <= 1'b0;
            txn_len_q  <= '0;
            txn_off_q  <= '0;
            tx_sent_q  <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            if (start) begin
                txn_last_q <= CHNL_TX_LAST;
                txn_len_q  <= CHNL_TX_LEN;
                txn_off_q  <= CHNL_TX_OFF;
            end
            // TXN handshake is independent of the data states.
            if (start) begin
                txn_q <= 1'b1;
            end else if (TXN_ACK) begin
                txn_q <= 1'b0;
            end
            if (start) begin
                tx_sent_q <= '0;
            end else if (beat) begin
                tx_sent_q <= tx_sent_q + 32'(Words);
            end
            tx_done_q <= term;
        end
    end

    assign CHNL_TX_ACK = (state_q == StAck);
    assign TXN         = txn_q;
    assign TXN_LAST    = txn_last_q;
    assign TXN_LEN     = txn_len_q;
    assign TXN_OFF     = txn_off_q;
    assign TX_SENT     = tx_sent_q;
    assign TX_DONE     = tx_done_q;

endmodule

// File: tb/tb_tx_port_channel_gate_sync.sv
// Bench for tx_port_channel_gate_sync: scenario tasks drive transactions and compare the DUT
// against a transaction-level model of expected FIFO writes, counts and handshake timing.
module tb_tx_port_channel_gate_sync;

    localparam int DW = 64;
    localparam int W  = DW / 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CHNL_TX = 1'b0;
    logic          CHNL_TX_ACK;
    logic          CHNL_TX_LAST = 1'b0;
    logic [31:0]   CHNL_TX_LEN = '0;
    logic [30:0]   CHNL_TX_OFF = '0;
    logic [DW-1:0] CHNL_TX_DATA = '0;
    logic          CHNL_TX_DATA_VALID = 1'b0;
    logic          CHNL_TX_DATA_REN;
    logic [DW:0]   WR_DATA;
    logic          WR_EN;
    logic          WR_FULL = 1'b0;
    logic          TXN;
    logic          TXN_ACK = 1'b0;
    logic          TXN_LAST;
    logic [31:0]   TXN_LEN;
    logic [30:0]   TXN_OFF;
    logic [31:0]   TX_SENT;
    logic          TX_DONE;

    tx_port_channel_gate_sync #(.C_DATA_WIDTH(DW)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .CHNL_TX           (CHNL_TX),
        .CHNL_TX_ACK       (CHNL_TX_ACK),
        .CHNL_TX_LAST      (CHNL_TX_LAST),
        .CHNL_TX_LEN       (CHNL_TX_LEN),
        .CHNL_TX_OFF       (CHNL_TX_OFF),
        .CHNL_TX_DATA      (CHNL_TX_DATA),
        .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
        .CHNL_TX_DATA_REN  (CHNL_TX_DATA_REN),
        .WR_DATA           (WR_DATA),
        .WR_EN             (WR_EN),
        .WR_FULL           (WR_FULL),
        .TXN               (TXN),
        .TXN_ACK           (TXN_ACK),
        .TXN_LAST          (TXN_LAST),
        .TXN_LEN           (TXN_LEN),
        .TXN_OFF           (TXN_OFF),
        .TX_SENT           (TX_SENT),
        .TX_DONE           (TX_DONE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Per-transaction stimulus: data-phase cycle i drives st_valid/st_full/st_data[i].
    logic          st_valid [0:63];
    logic          st_full  [0:63];
    logic [DW-1:0] st_data  [0:63];
    int            st_nd;        // data-phase cycles; CHNL_TX is low in the last one
    int            st_eop_full;  // cycles WR_FULL stays high after CHNL_TX drops
    int            st_ack;       // cycle TXN_ACK pulses (0 = never)
    logic [31:0]   st_len;
    logic [30:0]   st_off;
    logic          st_last;

    logic [DW:0]   exp_q [$];
    logic [DW:0]   got_q [$];

    task automatic fill_plain(input int nd);
        st_nd       = nd;
        st_eop_full = 0;
        for (int i = 0; i < 64; i++) begin
            st_valid[i] = 1'b1;
            st_full[i]  = 1'b0;
            st_data[i]  = DW'(i + 1);
        end
    endtask

    // Entered and left #1 after a rising edge. Cycle 0 raises CHNL_TX; ACK is due in cycle 1,
    // data cycles are 2..d with CHNL_TX low in cycle d, then the terminator waits out WR_FULL.
    task automatic run_txn(input string tag);
        int   d;
        int   acc;
        int   term_cyc;
        bit   term_seen;
        bit   finished;
        logic in_data;
        logic v;
        logic full;
        logic exp_ren;
        logic exp_done;
        logic exp_txn;
        d         = st_nd + 1;
        acc       = 0;
        term_cyc  = 0;
        term_seen = 1'b0;
        finished  = 1'b0;
        exp_q.delete();
        got_q.delete();
        CHNL_TX_LEN  = st_len;
        CHNL_TX_OFF  = st_off;
        CHNL_TX_LAST = st_last;
        for (int c = 0; c < 300 && !finished; c++) begin
            in_data = (c >= 2 && c <= d);
            CHNL_TX = (c < d);
            TXN_ACK = (st_ack != 0 && c == st_ack);
            if (in_data) begin
                v            = st_valid[c-2];
                full         = st_full[c-2];
                CHNL_TX_DATA = st_data[c-2];
            end else begin
                v            = 1'b0;
                full         = (c > d) ? (c - d <= st_eop_full) : 1'($urandom_range(0, 1));
                CHNL_TX_DATA = {$urandom, $urandom};
            end
            CHNL_TX_DATA_VALID = v;
            WR_FULL            = full;
            @(negedge CLK);
            exp_ren  = in_data && !full;
            exp_done = term_seen && (c == term_cyc + 1);
            exp_txn  = (st_ack == 0) || (c <= st_ack);
            n_cmp++;
            if (CHNL_TX_ACK !== (c == 1)) begin
                n_err++;
                $display("FAIL %s chnl_tx_ack c=%0d got=%b exp=%b", tag, c, CHNL_TX_ACK, c == 1);
            end
            n_cmp++;
            if (CHNL_TX_DATA_REN !== exp_ren) begin
                n_err++;
                $display("FAIL %s data_ren c=%0d got=%b exp=%b", tag, c, CHNL_TX_DATA_REN, exp_ren);
            end
            n_cmp++;
            if (WR_EN === 1'b1 && full) begin
                n_err++;
                $display("FAIL %s write_while_full c=%0d got=1 exp=0", tag, c);
            end
            n_cmp++;
            if (TX_DONE !== exp_done) begin
                n_err++;
                $display("FAIL %s tx_done c=%0d got=%b exp=%b", tag, c, TX_DONE, exp_done);
            end
            if (c >= 1) begin
                n_cmp++;
                if (TXN !== exp_txn) begin
                    n_err++;
                    $display("FAIL %s txn c=%0d got=%b exp=%b", tag, c, TXN, exp_txn);
                end
                n_cmp++;
                if (TX_SENT !== 32'(W * acc)) begin
                    n_err++;
                    $display("FAIL %s tx_sent c=%0d got=%0d exp=%0d", tag, c, TX_SENT, W * acc);
                end
                n_cmp++;
                if (TXN_LEN !== st_len || TXN_OFF !== st_off || TXN_LAST !== st_last) begin
                    n_err++;
                    $display("FAIL %s txn_fields c=%0d got=%h/%h/%b exp=%h/%h/%b", tag, c,
                             TXN_LEN, TXN_OFF, TXN_LAST, st_len, st_off, st_last);
                end
            end
            if (WR_EN === 1'b1) got_q.push_back(WR_DATA);
            if (in_data && v && !full) begin
                exp_q.push_back({1'b0, st_data[c-2]});
                acc++;
            end
            if (c > d && !term_seen && !full) begin
                exp_q.push_back({1'b1, {DW{1'b0}}});
                term_seen = 1'b1;
                term_cyc  = c;
            end
            if (term_seen && c >= term_cyc + 1 && (st_ack == 0 || c > st_ack)) finished = 1'b1;
            @(posedge CLK);
            #1;
        end
        TXN_ACK = 1'b0;
        WR_FULL = 1'b0;
        n_cmp++;
        if (!finished) begin
            n_err++;
            $display("FAIL %s timeout got=unfinished exp=finished", tag);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s write_count got=%0d exp=%0d", tag, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL %s write[%0d] got=%h exp=%h", tag, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if (CHNL_TX_ACK !== 1'b0 || CHNL_TX_DATA_REN !== 1'b0 || WR_EN !== 1'b0 ||
            WR_DATA !== '0 || TXN !== 1'b0 || TXN_LAST !== 1'b0 || TXN_LEN !== '0 ||
            TXN_OFF !== '0 || TX_SENT !== '0 || TX_DONE !== 1'b0) begin
            n_err++;
            $display("FAIL %s outputs got=ack%b ren%b wen%b wd%h txn%b l%b len%h off%h s%h d%b exp=0",
                     tag, CHNL_TX_ACK, CHNL_TX_DATA_REN, WR_EN, WR_DATA, TXN, TXN_LAST,
                     TXN_LEN, TXN_OFF, TX_SENT, TX_DONE);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_all_zero("post_reset");
    endtask

    task automatic test_basic();
        fill_plain(5);
        st_valid[4] = 1'b0;
        st_len  = 32'd8;
        st_off  = '0;
        st_last = 1'b1;
        st_ack  = 9;
        run_txn("basic");
    endtask

    task automatic test_backpressure();
        fill_plain(8);
        st_full[2]  = 1'b1;
        st_full[3]  = 1'b1;
        st_full[4]  = 1'b1;
        st_eop_full = 3;
        st_len  = 32'd14;
        st_off  = 31'h1234;
        st_last = 1'b0;
        st_ack  = 2;
        run_txn("backpressure");
    endtask

    task automatic test_beat_and_drop();
        fill_plain(2);
        st_data[1] = 64'hdead_beef_0bad_f00d;
        st_len  = 32'd4;
        st_off  = 31'h7;
        st_last = 1'b1;
        st_ack  = 1;
        run_txn("beat_and_drop");
    endtask

    task automatic test_zero_length();
        fill_plain(1);
        st_valid[0] = 1'b0;
        st_len  = 32'd0;
        st_off  = 31'h55;
        st_last = 1'b0;
        st_ack  = 1;
        run_txn("zero_len");
    endtask

    task automatic test_late_ack();
        fill_plain(3);
        st_len  = 32'd6;
        st_off  = 31'h100;
        st_last = 1'b0;
        st_ack  = 0;
        run_txn("late_ack_first");
        CHNL_TX      = 1'b1;
        CHNL_TX_LEN  = 32'd22;
        CHNL_TX_OFF  = 31'h200;
        CHNL_TX_LAST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            TXN_ACK = (k == 4);
            @(negedge CLK);
            n_cmp++;
            if (CHNL_TX_ACK !== 1'b0 || TXN !== 1'b1 || TXN_LEN !== 32'd6) begin
                n_err++;
                $display("FAIL late_ack_hold k=%0d got=ack%b txn%b len%0d exp=ack0 txn1 len6",
                         k, CHNL_TX_ACK, TXN, TXN_LEN);
            end
            @(posedge CLK);
            #1;
        end
        TXN_ACK = 1'b0;
        n_cmp++;
        if (TXN !== 1'b0 || CHNL_TX_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL late_ack_clear got=txn%b ack%b exp=txn0 ack0", TXN, CHNL_TX_ACK);
        end
        fill_plain(4);
        st_len  = 32'd22;
        st_off  = 31'h200;
        st_last = 1'b1;
        st_ack  = 3;
        run_txn("late_ack_second");
    endtask

    task automatic test_reset_mid_data();
        CHNL_TX            = 1'b1;
        CHNL_TX_LEN        = 32'h55;
        CHNL_TX_OFF        = 31'h33;
        CHNL_TX_LAST       = 1'b1;
        CHNL_TX_DATA_VALID = 1'b0;
        WR_FULL            = 1'b0;
        TXN_ACK            = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        CHNL_TX_DATA_VALID = 1'b1;
        CHNL_TX_DATA       = 64'h11;
        @(posedge CLK);
        #1;
        CHNL_TX_DATA = 64'h22;
        @(posedge CLK);
        #1;
        CHNL_TX_DATA_VALID = 1'b0;
        n_cmp++;
        if (TXN !== 1'b1 || TX_SENT !== 32'(2 * W)) begin
            n_err++;
            $display("FAIL pre_reset got=txn%b sent%0d exp=txn1 sent%0d", TXN, TX_SENT, 2 * W);
        end
        RST = 1'b1;
        #1;
        check_all_zero("reset_mid_data");
        @(negedge CLK);
        check_all_zero("reset_mid_data_held");
        CHNL_TX = 1'b0;
        RST     = 1'b0;
        @(posedge CLK);
        #1;
        fill_plain(3);
        st_len  = 32'd6;
        st_off  = 31'h9;
        st_last = 1'b0;
        st_ack  = 4;
        run_txn("after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            st_nd       = $urandom_range(1, 10);
            st_eop_full = $urandom_range(0, 3);
            st_ack      = $urandom_range(1, 14);
            st_len      = $urandom;
            st_off      = 31'($urandom);
            st_last     = 1'($urandom_range(0, 1));
            for (int i = 0; i < 64; i++) begin
                st_valid[i] = ($urandom_range(0, 3) != 0);
                st_full[i]  = ($urandom_range(0, 3) == 0);
                st_data[i]  = {$urandom, $urandom};
            end
            run_txn($sformatf("random%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_beat_and_drop();
        test_zero_length();
        test_late_ack();
        test_reset_mid_data();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
